// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline clock/reset controller.
// State encoding and pipeline stage indices used by pipe_clk_ctrl.
package pipe_pkg;

  // Controller state as presented on the 2-bit state output
  typedef enum logic [1:0] {
    ST_RSTSEQ = 2'd0,
    ST_HALTED = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } pipe_state_e;

  // Stage indices into stage_rst_n (IF releases first, WB last)
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;

  localparam int unsigned STAGE_CNT = STG_WB + 1;

  // True for states in which the pipeline advances every cycle
  function automatic logic is_advancing(input pipe_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/pipe_clk_ctrl_rst_sync.sv
// Reset-release synchroniser: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync_rst_n
);

  logic [STAGES-1:0] r_sync;

  // Shift ones in once reset is released; async clear on reset assertion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync_rst_n = r_sync[STAGES-1];

endmodule

// File: rtl/pipe_clk_ctrl.sv
// Consumer-side clock/reset controller for the pipelined core.
// Sequences per-stage reset release, gates pipeline advance (run/halt/step)
// and counts advanced cycles.
// Build option: PIPE_CLK_CNT_SAT_EN makes cycle_cnt saturate instead of wrap.
module pipe_clk_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_STAGES  = STAGE_CNT,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned STEP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic [STEP_W-1:0]     step_count,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  clk_en,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic                  step_done
);

  logic                  w_sync_rst_n;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  pipe_state_e           w_state_nxt;
  logic                  w_step_done_nxt;
  logic [STEP_W-1:0]     w_step_cnt_nxt;

  pipe_state_e           r_state;
  logic [NUM_STAGES-1:0] r_stage;
  logic                  r_clk_en;
  logic                  r_step_done;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [CNT_W-1:0]      r_cycle_cnt;

  rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_sync_rst_n (w_sync_rst_n)
  );

  // Stage release shifter input: synchronised reset enters at IF and walks toward WB
  always_comb begin
    w_stage_nxt         = r_stage << 1;
    w_stage_nxt[STG_IF] = w_sync_rst_n;
  end

  // Next-state, step counter and step_done decode
  always_comb begin
    w_state_nxt     = r_state;
    w_step_done_nxt = 1'b0;
    w_step_cnt_nxt  = r_step_cnt;
    case (r_state)
      ST_RSTSEQ: begin
        // leave reset sequencing on the edge the last stage is released
        if (w_stage_nxt[NUM_STAGES-1]) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (halt_req) begin
          w_state_nxt = ST_HALTED;
        end else if (step_req && (step_count != '0)) begin
          w_state_nxt    = ST_STEP;
          w_step_cnt_nxt = step_count;
        end else if (run_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req || !run_req) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_STEP: begin
        // each edge in STEP retires one advanced cycle
        if (halt_req || (r_step_cnt == STEP_W'(1))) begin
          w_state_nxt     = ST_HALTED;
          w_step_done_nxt = 1'b1;
          w_step_cnt_nxt  = '0;
        end else begin
          w_step_cnt_nxt = r_step_cnt - STEP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RSTSEQ;
      end
    endcase
  end

  // State, stage release and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RSTSEQ;
      r_stage     <= '0;
      r_clk_en    <= 1'b0;
      r_step_done <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_clk_en    <= is_advancing(w_state_nxt);
      r_step_done <= w_step_done_nxt;
      r_step_cnt  <= w_step_cnt_nxt;
    end
  end

  // Advanced-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (r_clk_en) begin
`ifdef PIPE_CLK_CNT_SAT_EN
      if (r_cycle_cnt != {CNT_W{1'b1}}) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
`else
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
`endif
    end
  end

  assign stage_rst_n = r_stage;
  assign clk_en      = r_clk_en;
  assign state       = r_state;
  assign cycle_cnt   = r_cycle_cnt;
  assign step_done   = r_step_done;

endmodule

// File: tb/tb_pipe_clk_ctrl.sv
// Scoreboard bench for pipe_clk_ctrl: a behavioural model pushes expected
// outputs each edge, a monitor pops and compares on the falling edge.
// A second instance with a 4-bit counter exercises wrap/saturation.
module tb_pipe_clk_ctrl;

  localparam int unsigned S = 2;
  localparam int unsigned N = 5;

  logic        clk;
  logic        rst_n;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [7:0]  step_count;

  logic [4:0]  stage_rst_n;
  logic        clk_en;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        step_done;

  logic [4:0]  s_stage_rst_n;
  logic        s_clk_en;
  logic [1:0]  s_state;
  logic [3:0]  s_cycle_cnt;
  logic        s_step_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_en     = 0;
  int n_done   = 0;

  typedef struct {
    logic [4:0]  stage;
    logic        en;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  pipe_clk_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .step_count  (step_count),
    .stage_rst_n (stage_rst_n),
    .clk_en      (clk_en),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .step_done   (step_done)
  );

  pipe_clk_ctrl #(.CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .step_count  (step_count),
    .stage_rst_n (s_stage_rst_n),
    .clk_en      (s_clk_en),
    .state       (s_state),
    .cycle_cnt   (s_cycle_cnt),
    .step_done   (s_step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: mode 0=RSTSEQ 1=HALTED 2=RUN 3=STEP, evaluated at each rising edge
  initial begin
    int     rel;
    int     mode;
    int     left;
    longint adv;
    bit     en;
    bit     done;
    exp_t   e;
    rel = 0; mode = 0; left = 0; adv = 0; en = 0; done = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        rel = 0; mode = 0; left = 0; adv = 0; en = 0; done = 0;
      end else begin
        if (en) adv++;
        done = 0;
        if (rel < 1000) rel++;
        case (mode)
          0: if (rel >= int'(S + N)) mode = 1;
          1: begin
            if (halt_req) mode = 1;
            else if (step_req && step_count != 0) begin
              mode = 3;
              left = int'(step_count);
            end else if (run_req) mode = 2;
          end
          2: if (halt_req || !run_req) mode = 1;
          default: begin
            left--;
            if (halt_req || left == 0) begin
              mode = 1;
              done = 1;
            end
          end
        endcase
        en = (mode == 2) || (mode == 3);
      end
      for (int i = 0; i < int'(N); i++) e.stage[i] = (rel >= int'(S) + 1 + i);
      e.en   = en;
      e.st   = 2'(mode);
      e.cnt  = 32'(adv);
`ifdef PIPE_CLK_CNT_SAT_EN
      e.cnt4 = (adv > 15) ? 4'd15 : 4'(adv);
`else
      e.cnt4 = 4'(adv % 16);
`endif
      e.done = done;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation on each falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clk_en) n_en++;
      if (step_done) n_done++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stage_rst_n", 64'(stage_rst_n), 64'(e.stage));
        chk("clk_en",      64'(clk_en),      64'(e.en));
        chk("state",       64'(state),       64'(e.st));
        chk("cycle_cnt",   64'(cycle_cnt),   64'(e.cnt));
        chk("step_done",   64'(step_done),   64'(e.done));
        chk("s_stage",     64'(s_stage_rst_n), 64'(e.stage));
        chk("s_clk_en",    64'(s_clk_en),    64'(e.en));
        chk("s_state",     64'(s_state),     64'(e.st));
        chk("s_cycle_cnt", 64'(s_cycle_cnt), 64'(e.cnt4));
        chk("s_step_done", 64'(s_step_done), 64'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(7);
  endtask

  // Stimulus: directed scenarios followed by randomized requests
  initial begin
    int en0;
    int dn0;
    int r;
    rst_n = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; step_count = 8'd0;

    // reset release sequence
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("rel_edge3_stage", 64'(stage_rst_n), 64'h01);
    cyc(3);
    chk("rel_edge6_stage", 64'(stage_rst_n), 64'h0f);
    chk("rel_edge6_state", 64'(state), 64'd0);
    cyc(1);
    chk("rel_edge7_stage", 64'(stage_rst_n), 64'h1f);
    chk("rel_edge7_state", 64'(state), 64'd1);

    // single step of 3
    en0 = n_en; dn0 = n_done;
    step_req = 1'b1; step_count = 8'd3;
    cyc(1);
    step_req = 1'b0;
    cyc(5);
    chk("step3_en_cycles", 64'(n_en - en0), 64'd3);
    chk("step3_done",      64'(n_done - dn0), 64'd1);
    chk("step3_cnt",       64'(cycle_cnt), 64'd3);

    // run 10 cycles then halt
    do_reset();
    run_req = 1'b1;
    cyc(10);
    halt_req = 1'b1; run_req = 1'b0;
    cyc(1);
    halt_req = 1'b0;
    chk("run_halt_en",  64'(clk_en), 64'd0);
    cyc(2);
    chk("run_halt_cnt", 64'(cycle_cnt), 64'd10);

    // aborted long step
    do_reset();
    dn0 = n_done;
    step_req = 1'b1; step_count = 8'd200;
    cyc(1);
    step_req = 1'b0;
    cyc(4);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("abort_en", 64'(clk_en), 64'd0);
    cyc(2);
    chk("abort_done", 64'(n_done - dn0), 64'd1);
    chk("abort_cnt",  64'(cycle_cnt), 64'd5);

    // zero-length step ignored; run+step together enters STEP
    en0 = n_en;
    step_req = 1'b1; step_count = 8'd0;
    cyc(1);
    step_req = 1'b0;
    cyc(2);
    chk("step0_state", 64'(state), 64'd1);
    chk("step0_en",    64'(n_en - en0), 64'd0);
    run_req = 1'b1; step_req = 1'b1; step_count = 8'd2;
    cyc(1);
    step_req = 1'b0; run_req = 1'b0;
    chk("runstep_state", 64'(state), 64'd3);
    cyc(4);

    // async reset while running, then replay
    run_req = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("async_stage", 64'(stage_rst_n), 64'd0);
    chk("async_en",    64'(clk_en), 64'd0);
    chk("async_state", 64'(state), 64'd0);
    chk("async_cnt",   64'(cycle_cnt), 64'd0);
    chk("async_done",  64'(step_done), 64'd0);
    chk("async_cnt4",  64'(s_cycle_cnt), 64'd0);
    run_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(7);
    chk("replay_state", 64'(state), 64'd1);

    // 4-bit counter over 17 advanced cycles
    run_req = 1'b1;
    cyc(17);
    run_req = 1'b0;
    cyc(2);
`ifdef PIPE_CLK_CNT_SAT_EN
    chk("cnt4_sat", 64'(s_cycle_cnt), 64'd15);
`else
    chk("cnt4_wrap", 64'(s_cycle_cnt), 64'd1);
`endif

    // randomized requests with occasional resets
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 99));
      halt_req = 1'b0;
      step_req = 1'b0;
      rst_n    = 1'b1;
      if (r < 5) run_req = ~run_req;
      else if (r < 11) halt_req = 1'b1;
      else if (r < 22) begin
        step_req   = 1'b1;
        step_count = ($urandom_range(0, 9) == 0) ? 8'd40 : 8'($urandom_range(0, 6));
      end else if (r < 24) begin
        step_req = 1'b1;
        halt_req = 1'b1;
      end else if (r == 99) rst_n = 1'b0;
      cyc(1);
    end
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0; rst_n = 1'b1;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
